// File: rtl/note_judge.sv
// Hit-judgement stage for the two-lane note queue: matches key presses against the
// notes at the hit line and keeps score, combo, max combo, HP and the game-over flag.
module note_judge #(
  parameter int PERFECT_PTS = 300,
  parameter int GREAT_PTS   = 150,
  parameter int HP_INIT     = 100,
  parameter int HP_MISS     = 10,
  parameter int COMBO_MAX   = 999
) (
  input  logic        clk_div,
  input  logic        rst_n,
  input  logic        start,
  input  logic        game_en,
  input  logic        key_up,
  input  logic        key_down,
  input  logic [15:0] noteup_bit0,
  input  logic [15:0] noteup_bit1,
  input  logic [15:0] notedown_bit0,
  input  logic [15:0] notedown_bit1,
  output logic [1:0]  judge_up,
  output logic [1:0]  judge_down,
  output logic [15:0] score,
  output logic [9:0]  combo,
  output logic [9:0]  max_combo,
  output logic [7:0]  hp,
  output logic        game_over
);

  localparam logic [10:0] PERF_X1  = 11'(PERFECT_PTS);
  localparam logic [10:0] PERF_X2  = 11'(2 * PERFECT_PTS);
  localparam logic [10:0] GREAT_X1 = 11'(GREAT_PTS);
  localparam logic [10:0] GREAT_X2 = 11'(2 * GREAT_PTS);
  localparam logic [8:0]  LOSS_X1  = 9'(HP_MISS);
  localparam logic [8:0]  LOSS_X2  = 9'(2 * HP_MISS);
  localparam logic [7:0]  HP_START = 8'(HP_INIT);
  localparam logic [9:0]  COMBO_SAT = 10'(COMBO_MAX);

  logic [15:0] bit0_lane [2];
  logic [15:0] bit1_lane [2];
  logic [1:0]  key_in;
  logic [1:0]  key_q;
  logic [1:0]  cons_q [2];
  logic        active;

  logic        perfect   [2];
  logic        great     [2];
  logic        miss      [2];
  logic [10:0] lane_pts  [2];
  logic [1:0]  judge_nxt [2];
  logic [1:0]  cons_nxt  [2];

  assign bit0_lane[0] = noteup_bit0;
  assign bit1_lane[0] = noteup_bit1;
  assign bit0_lane[1] = notedown_bit0;
  assign bit1_lane[1] = notedown_bit1;
  assign key_in       = {key_down, key_up};
  assign active       = game_en & ~game_over & ~start;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      logic [1:0] code0;
      logic [1:0] code1;
      logic       press;
      logic       live0;
      logic       live1;
      logic       hit_p;
      logic       hit_g;
      logic       lmiss;

      assign code0 = {bit1_lane[gi][0], bit0_lane[gi][0]};
      assign code1 = {bit1_lane[gi][1], bit0_lane[gi][1]};
      assign press = key_in[gi] & ~key_q[gi];
      // A note that was already taken as GREAT at pos1 must not be judged again at pos0.
      assign live0 = (code0 != 2'b00) & ~cons_q[gi][0];
      assign live1 = (code1 != 2'b00) & ~cons_q[gi][1];
      assign hit_p = active & press & live0;
      assign hit_g = active & press & ~live0 & live1;
      assign lmiss = active & live0 & ~hit_p;

      assign perfect[gi] = hit_p;
      assign great[gi]   = hit_g;
      assign miss[gi]    = lmiss;
      assign lane_pts[gi] = hit_p ? ((code0 == 2'b10) ? PERF_X2 : PERF_X1) :
                            hit_g ? ((code1 == 2'b10) ? GREAT_X2 : GREAT_X1) : 11'd0;
      assign judge_nxt[gi] = lmiss ? 2'b11 : hit_p ? 2'b01 : hit_g ? 2'b10 : 2'b00;
      assign cons_nxt[gi]  = {1'b0, cons_q[gi][1] | hit_g};
    end
  endgenerate

  logic [1:0]  hits;
  logic [1:0]  misses;
  logic [16:0] score_sum;
  logic [15:0] score_nxt;
  logic [10:0] combo_sum;
  logic [9:0]  combo_nxt;
  logic [9:0]  max_nxt;
  logic [8:0]  hp_loss;
  logic [7:0]  hp_nxt;

  assign hits      = {1'b0, perfect[0] | great[0]} + {1'b0, perfect[1] | great[1]};
  assign misses    = {1'b0, miss[0]} + {1'b0, miss[1]};
  assign score_sum = {1'b0, score} + {6'd0, lane_pts[0]} + {6'd0, lane_pts[1]};
  assign score_nxt = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  assign combo_sum = ((misses != 2'd0) ? 11'd0 : {1'b0, combo}) + {9'd0, hits};
  assign combo_nxt = (combo_sum > {1'b0, COMBO_SAT}) ? COMBO_SAT : combo_sum[9:0];
  assign max_nxt   = (combo_nxt > max_combo) ? combo_nxt : max_combo;
  assign hp_loss   = (misses == 2'd2) ? LOSS_X2 : (misses == 2'd1) ? LOSS_X1 : 9'd0;
  assign hp_nxt    = ({1'b0, hp} > hp_loss) ? (hp - hp_loss[7:0]) : 8'd0;

  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      key_q      <= 2'b00;
      cons_q[0]  <= 2'b00;
      cons_q[1]  <= 2'b00;
      judge_up   <= 2'b00;
      judge_down <= 2'b00;
      score      <= 16'd0;
      combo      <= 10'd0;
      max_combo  <= 10'd0;
      hp         <= HP_START;
      game_over  <= 1'b0;
    end else begin
      key_q <= key_in;
      if (start) begin
        cons_q[0]  <= 2'b00;
        cons_q[1]  <= 2'b00;
        judge_up   <= 2'b00;
        judge_down <= 2'b00;
        score      <= 16'd0;
        combo      <= 10'd0;
        max_combo  <= 10'd0;
        hp         <= HP_START;
        game_over  <= 1'b0;
      end else if (active) begin
        cons_q[0]  <= cons_nxt[0];
        cons_q[1]  <= cons_nxt[1];
        judge_up   <= judge_nxt[0];
        judge_down <= judge_nxt[1];
        score      <= score_nxt;
        combo      <= combo_nxt;
        max_combo  <= max_nxt;
        hp         <= hp_nxt;
        game_over  <= (hp_nxt == 8'd0);
      end else begin
        // Frozen: stats hold, pulses drop, and stale consumed marks are forgotten.
        cons_q[0]  <= 2'b00;
        cons_q[1]  <= 2'b00;
        judge_up   <= 2'b00;
        judge_down <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_note_judge.sv
// Randomised scoreboard bench for note_judge: a note-object model of both lanes predicts
// each cycle's registered outputs, and a monitor compares them one cycle later.
module tb_note_judge;

  logic        clk_div = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        game_en = 1'b0;
  logic        key_up = 1'b0;
  logic        key_down = 1'b0;
  logic [15:0] noteup_bit0 = '0;
  logic [15:0] noteup_bit1 = '0;
  logic [15:0] notedown_bit0 = '0;
  logic [15:0] notedown_bit1 = '0;
  logic [1:0]  judge_up;
  logic [1:0]  judge_down;
  logic [15:0] score;
  logic [9:0]  combo;
  logic [9:0]  max_combo;
  logic [7:0]  hp;
  logic        game_over;

  note_judge dut (
    .clk_div(clk_div), .rst_n(rst_n), .start(start), .game_en(game_en),
    .key_up(key_up), .key_down(key_down),
    .noteup_bit0(noteup_bit0), .noteup_bit1(noteup_bit1),
    .notedown_bit0(notedown_bit0), .notedown_bit1(notedown_bit1),
    .judge_up(judge_up), .judge_down(judge_down), .score(score), .combo(combo),
    .max_combo(max_combo), .hp(hp), .game_over(game_over)
  );

  always #5 clk_div = ~clk_div;

  typedef struct {
    int ju; int jd; int score; int combo; int maxc; int hp; int go;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  // Lane model: each slot holds a note code and whether that note has already been hit.
  logic [1:0] note_code [2][16];
  bit         note_used [2][16];
  bit         key_prev  [2];
  int m_score, m_combo, m_max, m_hp, m_go;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic clear_used();
    for (int l = 0; l < 2; l++)
      for (int i = 0; i < 16; i++) note_used[l][i] = 1'b0;
  endtask

  task automatic model_reset();
    m_score = 0; m_combo = 0; m_max = 0; m_hp = 100; m_go = 0;
    key_prev[0] = 1'b0; key_prev[1] = 1'b0;
    clear_used();
  endtask

  function automatic int mult(input logic [1:0] c);
    return (c == 2'b10) ? 2 : 1;
  endfunction

  // mode 0 random play, 1 auto-player, 2 no keys, 3 random keys, 4 start pulse
  task automatic drive_cycle(input int mode);
    bit k [2];
    bit st, en, act, press, live0, live1, perf, grt, mis;
    int judge [2];
    int pts, hits, misses, dens;
    logic [1:0] newc;
    exp_t e;
    st = 1'b0; en = 1'b1;
    for (int l = 0; l < 2; l++) begin
      case (mode)
        0: k[l] = 1'($urandom_range(0, 1));
        1: k[l] = (note_code[l][0] != 2'b00);
        3: k[l] = 1'($urandom_range(0, 1));
        default: k[l] = 1'b0;
      endcase
    end
    if (mode == 0) begin
      st = ($urandom_range(0, 49) == 0);
      en = ($urandom_range(0, 9) != 0);
    end
    if (mode == 4) st = 1'b1;

    start = st; game_en = en; key_up = k[0]; key_down = k[1];
    for (int i = 0; i < 16; i++) begin
      noteup_bit0[i] = note_code[0][i][0];   noteup_bit1[i] = note_code[0][i][1];
      notedown_bit0[i] = note_code[1][i][0]; notedown_bit1[i] = note_code[1][i][1];
    end

    act = en && (m_go == 0) && !st;
    pts = 0; hits = 0; misses = 0;
    for (int l = 0; l < 2; l++) begin
      judge[l] = 0;
      if (act) begin
        press = k[l] && !key_prev[l];
        live0 = (note_code[l][0] != 2'b00) && !note_used[l][0];
        live1 = (note_code[l][1] != 2'b00) && !note_used[l][1];
        perf = 1'b0; grt = 1'b0; mis = 1'b0;
        if (press && live0) begin
          perf = 1'b1; pts += 300 * mult(note_code[l][0]); hits++;
        end else if (press && live1) begin
          grt = 1'b1; pts += 150 * mult(note_code[l][1]); hits++;
          note_used[l][1] = 1'b1;
        end
        if (live0 && !perf) begin mis = 1'b1; misses++; end
        judge[l] = mis ? 3 : perf ? 1 : grt ? 2 : 0;
      end
    end

    if (st) begin
      m_score = 0; m_combo = 0; m_max = 0; m_hp = 100; m_go = 0;
      clear_used();
    end else if (act) begin
      m_score = (m_score + pts > 65535) ? 65535 : m_score + pts;
      m_combo = ((misses > 0) ? 0 : m_combo) + hits;
      if (m_combo > 999) m_combo = 999;
      if (m_combo > m_max) m_max = m_combo;
      m_hp = (m_hp - 10 * misses < 0) ? 0 : m_hp - 10 * misses;
      if (m_hp == 0) m_go = 1;
    end else begin
      clear_used();
    end
    key_prev[0] = k[0]; key_prev[1] = k[1];

    e.ju = judge[0]; e.jd = judge[1]; e.score = m_score; e.combo = m_combo;
    e.maxc = m_max; e.hp = m_hp; e.go = m_go;
    exp_q.push_back(e);

    // Advance the queue one step; the auto-player leaves a gap after every note.
    dens = (mode == 2) ? 70 : 40;
    for (int l = 0; l < 2; l++) begin
      if (mode == 1)
        newc = (note_code[l][15] == 2'b00 && $urandom_range(0, 9) != 0) ?
               2'($urandom_range(1, 3)) : 2'b00;
      else
        newc = ($urandom_range(0, 99) < dens) ? 2'($urandom_range(1, 3)) : 2'b00;
      for (int i = 0; i < 15; i++) begin
        note_code[l][i] = note_code[l][i+1];
        note_used[l][i] = note_used[l][i+1];
      end
      note_code[l][15] = newc;
      note_used[l][15] = 1'b0;
    end
    cyc++;
  endtask

  task automatic do_reset(input int mode_after);
    @(negedge clk_div);
    rst_n = 1'b0;
    #1;
    check("rst_judge_up", judge_up, 0);
    check("rst_judge_down", judge_down, 0);
    check("rst_score", score, 0);
    check("rst_combo", combo, 0);
    check("rst_max_combo", max_combo, 0);
    check("rst_hp", hp, 100);
    check("rst_game_over", game_over, 0);
    model_reset();
    @(negedge clk_div);
    rst_n = 1'b1;
    drive_cycle(mode_after);
  endtask

  // Monitor: every registered output set is compared just after the edge that produced it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_div);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("judge_up", judge_up, e.ju);
        check("judge_down", judge_down, e.jd);
        check("score", score, e.score);
        check("combo", combo, e.combo);
        check("max_combo", max_combo, e.maxc);
        check("hp", hp, e.hp);
        check("game_over", game_over, e.go);
        if (e.ju != 0 || e.jd != 0)
          $display("txn cyc=%0d judge_up=%0d judge_down=%0d score=%0d combo=%0d hp=%0d",
                   cyc, judge_up, judge_down, score, combo, hp);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int l = 0; l < 2; l++)
      for (int i = 0; i < 16; i++) note_code[l][i] = 2'b00;
    model_reset();

    do_reset(1);
    repeat (1300) begin @(negedge clk_div); drive_cycle(1); end
    @(negedge clk_div);
    check("score_saturated", score, 65535);
    check("combo_saturated", combo, 999);
    drive_cycle(2);
    repeat (30) begin @(negedge clk_div); drive_cycle(2); end
    @(negedge clk_div);
    check("hp_drained", hp, 0);
    check("game_over_set", game_over, 1);
    drive_cycle(3);
    repeat (30) begin @(negedge clk_div); drive_cycle(3); end
    @(negedge clk_div); drive_cycle(4);
    @(negedge clk_div);
    check("start_hp", hp, 100);
    check("start_game_over", game_over, 0);
    drive_cycle(0);
    repeat (2000) begin @(negedge clk_div); drive_cycle(0); end

    do_reset(0);
    repeat (300) begin @(negedge clk_div); drive_cycle(0); end
    @(negedge clk_div);
    @(negedge clk_div);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
